// File: rtl/score_comparator_pkg.sv
// Shared definitions for the alignment-cell comparator and its downstream selector.
package score_comparator_pkg;

    localparam int unsigned SCORE_W_DEFAULT = 8;

    // One-hot winner codes, also decoded by the score selector stage
    localparam logic [2:0] SEL_MATCH    = 3'b100;
    localparam logic [2:0] SEL_MISMATCH = 3'b010;
    localparam logic [2:0] SEL_GAP      = 3'b001;

endpackage

// File: rtl/score_max2.sv
// Combinational signed 2-input max; a tie goes to the first operand.
module score_max2 #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                a_wins_c,
    output logic signed [W-1:0] max_c
);

    // First operand wins unless the second is strictly greater
    always_comb begin
        a_wins_c = (a >= b);
        max_c    = a_wins_c ? a : b;
    end

endmodule

// File: rtl/score_comparator.sv
// Two-stage streaming comparator producing the one-hot selection code for one
// alignment cell. Optional saturating winner statistics: SCORE_COMPARATOR_STATS_EN.
module score_comparator
    import score_comparator_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEFAULT,
    parameter int unsigned IDX_W   = 10
`ifdef SCORE_COMPARATOR_STATS_EN
    ,
    parameter int unsigned STAT_W  = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [SCORE_W-1:0] in_match,
    input  logic signed [SCORE_W-1:0] in_mismatch,
    input  logic signed [SCORE_W-1:0] in_gap,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_sel,
    output logic signed [SCORE_W-1:0] out_score,
    output logic                      out_last,
    output logic [IDX_W-1:0]          out_idx
`ifdef SCORE_COMPARATOR_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [STAT_W-1:0]         stat_match,
    output logic [STAT_W-1:0]         stat_mismatch,
    output logic [STAT_W-1:0]         stat_gap
`endif
);

    logic                      s1_valid;
    logic [2:0]                s1_sel;
    logic signed [SCORE_W-1:0] s1_score;
    logic signed [SCORE_W-1:0] s1_gap;
    logic                      s1_last;
    logic                      s2_valid;
    logic [IDX_W-1:0]          idx_cnt;

    logic                      s1_advance;
    logic                      s1_load;
    logic                      s2_load;
    logic                      st1_match_wins_c;
    logic signed [SCORE_W-1:0] st1_max_c;
    logic                      st2_keep_c;
    logic signed [SCORE_W-1:0] st2_max_c;

    // Stage 2 drains when empty or accepted; stage 1 accepts when it can move on
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign s1_load    = in_valid && in_ready;
    assign s2_load    = s1_valid && s1_advance;
    assign out_valid  = s2_valid;

    score_max2 #(.W(SCORE_W)) u_max_st1 (
        .a        (in_match),
        .b        (in_mismatch),
        .a_wins_c (st1_match_wins_c),
        .max_c    (st1_max_c)
    );

    score_max2 #(.W(SCORE_W)) u_max_st2 (
        .a        (s1_score),
        .b        (s1_gap),
        .a_wins_c (st2_keep_c),
        .max_c    (st2_max_c)
    );

    // Stage 1: register the match-vs-mismatch winner alongside gap and last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= 3'b000;
            s1_score <= '0;
            s1_gap   <= '0;
            s1_last  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_sel   <= st1_match_wins_c ? SEL_MATCH : SEL_MISMATCH;
            s1_score <= st1_max_c;
            s1_gap   <= in_gap;
            s1_last  <= in_last;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: settle against gap, stamp the row index; a load beats a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sel   <= 3'b000;
            out_score <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            idx_cnt   <= '0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            out_sel   <= st2_keep_c ? s1_sel : SEL_GAP;
            out_score <= st2_max_c;
            out_last  <= s1_last;
            out_idx   <= idx_cnt;
            idx_cnt   <= s1_last ? '0 : idx_cnt + IDX_W'(1);
        end else if (out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

`ifdef SCORE_COMPARATOR_STATS_EN
    logic out_fire;
    assign out_fire = s2_valid && out_ready;

    // Saturating per-winner counters; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_match    <= '0;
            stat_mismatch <= '0;
            stat_gap      <= '0;
        end else if (stat_clr) begin
            stat_match    <= '0;
            stat_mismatch <= '0;
            stat_gap      <= '0;
        end else if (out_fire) begin
            if (out_sel == SEL_MATCH && stat_match != '1)
                stat_match <= stat_match + STAT_W'(1);
            if (out_sel == SEL_MISMATCH && stat_mismatch != '1)
                stat_mismatch <= stat_mismatch + STAT_W'(1);
            if (out_sel == SEL_GAP && stat_gap != '1)
                stat_gap <= stat_gap + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_score_comparator.sv
// Self-checking bench for score_comparator: directed cases plus randomized
// traffic with backpressure against a queue-based reference model.
module tb_score_comparator;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_match;
    logic signed [7:0] in_mismatch;
    logic signed [7:0] in_gap;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_sel;
    logic signed [7:0] out_score;
    logic              out_last;
    logic [9:0]        out_idx;
`ifdef SCORE_COMPARATOR_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_match;
    logic [15:0]       stat_mismatch;
    logic [15:0]       stat_gap;
`endif

    score_comparator #(.SCORE_W(8), .IDX_W(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_match    (in_match),
        .in_mismatch (in_mismatch),
        .in_gap      (in_gap),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .out_score   (out_score),
        .out_last    (out_last),
        .out_idx     (out_idx)
`ifdef SCORE_COMPARATOR_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_match    (stat_match),
        .stat_mismatch (stat_mismatch),
        .stat_gap      (stat_gap)
`endif
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] score;
        logic       last;
        logic [9:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_idx  = 0;
    int   fire_cnt = 0;
    int   m_stat[3];
    bit   bp = 0;

    logic       prev_stall = 1'b0;
    logic [2:0] prev_sel;
    logic [7:0] prev_score;
    logic       prev_last;
    logic [9:0] prev_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: highest score wins, earliest of match/mismatch/gap on ties
    function automatic exp_t model(input int m, input int mm, input int g,
                                   input logic last, input int idx);
        exp_t e;
        int best;
        best  = m;
        e.sel = 3'b100;
        if (mm > best) begin best = mm; e.sel = 3'b010; end
        if (g > best)  begin best = g;  e.sel = 3'b001; end
        e.score = 8'(best);
        e.last  = last;
        e.idx   = 10'(idx);
        return e;
    endfunction

    // Monitor: scoreboard, hold-stability and one-hot checks at the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
            prev_stall = 1'b0;
            for (int i = 0; i < 3; i++) m_stat[i] = 0;
        end else begin
            if (out_valid) chk("onehot", 32'($countones(out_sel)), 32'd1);
            if (prev_stall) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_sel",   {29'b0, out_sel},   {29'b0, prev_sel});
                chk("hold_score", {24'b0, out_score}, {24'b0, prev_score});
                chk("hold_last",  {31'b0, out_last},  {31'b0, prev_last});
                chk("hold_idx",   {22'b0, out_idx},   {22'b0, prev_idx});
            end
`ifdef SCORE_COMPARATOR_STATS_EN
            if (stat_clr) for (int i = 0; i < 3; i++) m_stat[i] = 0;
`endif
            if (out_valid && out_ready) begin
                fire_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sel",   {29'b0, out_sel},   {29'b0, e.sel});
                    chk("score", {24'b0, out_score}, {24'b0, e.score});
                    chk("last",  {31'b0, out_last},  {31'b0, e.last});
                    chk("idx",   {22'b0, out_idx},   {22'b0, e.idx});
`ifdef SCORE_COMPARATOR_STATS_EN
                    if (!stat_clr) begin
                        if (e.sel == 3'b100) m_stat[0]++;
                        if (e.sel == 3'b010) m_stat[1]++;
                        if (e.sel == 3'b001) m_stat[2]++;
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_match), int'(in_mismatch), int'(in_gap),
                                      in_last, m_idx));
                m_idx = in_last ? 0 : (m_idx + 1) % 1024;
            end
            prev_stall = out_valid && !out_ready;
            prev_sel   = out_sel;
            prev_score = out_score;
            prev_last  = out_last;
            prev_idx   = out_idx;
        end
    end

    // Present one beat until accepted; returns number of cycles it waited
    task automatic send(input int m, input int mm, input int g, input logic last,
                        output int waits);
        waits       = 0;
        in_match    = 8'(m);
        in_mismatch = 8'(mm);
        in_gap      = 8'(g);
        in_last     = last;
        in_valid    = 1'b1;
        forever begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int w;
    int acc;
    int k;
    int f0;
    int sm[6];
    int smm[6];
    int sg[6];

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_match = '0; in_mismatch = '0; in_gap = '0; in_last = 1'b0;
`ifdef SCORE_COMPARATOR_STATS_EN
        stat_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sel",   {29'b0, out_sel},   32'd0);
        chk("rst_out_score", {24'b0, out_score}, 32'd0);
        chk("rst_out_last",  {31'b0, out_last},  32'd0);
        chk("rst_out_idx",   {22'b0, out_idx},   32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First beat and its two-cycle latency
        send(5, 3, -2, 1'b0, w);
        @(negedge clk);
        chk("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
        chk("first_sel",   {29'b0, out_sel},   32'b100);
        chk("first_score", {24'b0, out_score}, 32'd5);
        chk("first_idx",   {22'b0, out_idx},   32'd0);
        @(posedge clk); #1;
        drain();

        // Tie-break cases
        send(4, 4, 4, 1'b0, w);
        send(-8, 1, 1, 1'b0, w);
        send(-8, -3, -1, 1'b1, w);
        drain();

        // Six back-to-back beats, row ends on beat 3
        f0 = fire_cnt;
        for (int i = 0; i < 6; i++) begin
            send(i, 2, 3 - i, (i == 2), w);
            chk("stream_no_wait", 32'(w), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        chk("stream_fires", 32'(fire_cnt - f0), 32'd6);
        drain();

        // Stall with input streaming: two beats fill the pipeline
        for (int i = 0; i < 6; i++) begin
            sm[i] = 10 * i; smm[i] = 25; sg[i] = 7 * i - 5;
        end
        out_ready = 1'b0;
        acc = 0; k = 0;
        for (int c = 0; c < 4; c++) begin
            in_match = 8'(sm[k]); in_mismatch = 8'(smm[k]); in_gap = 8'(sg[k]);
            in_last = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin acc++; k++; end
            @(posedge clk); #1;
        end
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        while (k < 6) begin
            send(sm[k], smm[k], sg[k], (k == 5), w);
            k++;
        end
        drain();

        // Asynchronous reset with two beats in flight, mid-row
        send(1, 2, 3, 1'b0, w);
        send(9, 2, 3, 1'b0, w);
        send(1, 9, 3, 1'b0, w);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out_idx",   {22'b0, out_idx},   32'd0);
        chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 0, 50, 1'b0, w);
        send(7, 0, 0, 1'b1, w);
        drain();

        // Randomized traffic with random backpressure and idle gaps
        bp = 1;
        for (int i = 0; i < 300; i++) begin
            int m, mm, g;
            if ($urandom_range(0, 2) == 0) begin
                m  = int'($urandom_range(0, 6)) - 3;
                mm = int'($urandom_range(0, 6)) - 3;
                g  = int'($urandom_range(0, 6)) - 3;
            end else begin
                m  = int'($urandom_range(0, 255)) - 128;
                mm = int'($urandom_range(0, 255)) - 128;
                g  = int'($urandom_range(0, 255)) - 128;
            end
            send(m, mm, g, ($urandom_range(0, 4) == 0), w);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end
        bp = 0;
        drain();

`ifdef SCORE_COMPARATOR_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        send(5, 1, 1, 1'b0, w);
        send(0, 0, 0, 1'b0, w);
        send(-1, -2, -3, 1'b0, w);
        send(1, 2, 2, 1'b0, w);
        send(-5, 3, 0, 1'b0, w);
        send(0, 0, 1, 1'b1, w);
        drain();
        @(posedge clk); #1;
        chk("stat_match",    {16'b0, stat_match},    32'd3);
        chk("stat_mismatch", {16'b0, stat_mismatch}, 32'd2);
        chk("stat_gap",      {16'b0, stat_gap},      32'd1);
        chk("stat_match_model", {16'b0, stat_match}, 32'(m_stat[0]));
        out_ready = 1'b0;
        send(9, 0, 0, 1'b1, w);
        @(posedge clk); #1;
        stat_clr  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        stat_clr  = 1'b0;
        chk("clr_match",    {16'b0, stat_match},    32'd0);
        chk("clr_mismatch", {16'b0, stat_mismatch}, 32'd0);
        chk("clr_gap",      {16'b0, stat_gap},      32'd0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_comparator.md
Name: score_comparator

Overview:
- Streaming comparator for the alignment cell datapath. Takes the three candidate scores of one cell (diagonal-match, diagonal-mismatch, gap) and produces the 3-bit one-hot selection code consumed by the score selector stage, plus the winning score.
- Sits directly upstream of the selector. It is the producer of the `sel` encoding (100 = match, 010 = mismatch, 001 = gap).
- Two-stage pipeline with ready/valid handshakes on both sides and a per-row cell index.

Parameters:
- SCORE_W, 8, width of each signed two's-complement candidate score.
- IDX_W, 10, width of the cell index counter within a row.
- STAT_W, 16, width of each statistics counter (used only with the optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_match  input  SCORE_W  signed candidate score via match path.
- in_mismatch  input  SCORE_W  signed candidate score via mismatch path.
- in_gap  input  SCORE_W  signed candidate score via gap path.
- in_last  input  1  beat is the last cell of a row.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_sel  output  3  one-hot winner: 100 match, 010 mismatch, 001 gap.
- out_score  output  SCORE_W  winning score.
- out_last  output  1  in_last delayed with its beat.
- out_idx  output  IDX_W  0-based cell position of the beat within its row.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - Both stage valids clear. out_valid=0, out_sel=000, out_score=0, out_last=0, out_idx=0. Index counter=0.
  - In-flight beats are discarded; there is no partial-row recovery.
- Handshakes:
  - A beat transfers when valid & ready on the same edge.
  - in_ready = !s1_valid | s1_advance.
  - s1_advance = !s2_valid | out_ready.
  - out_valid = s2_valid.
  - in_ready is combinational from out_ready (no skid). Full throughput of 1 beat/cycle when out_ready is held high.
- Stage 1:
  - Registers the result of match vs mismatch. Winner is match if in_match >= in_mismatch (signed compare). The winner's code and score are registered together with in_gap and in_last.
- Stage 2:
  - Compares the stage-1 winner against gap. Gap wins only if strictly greater.
  - Registers out_sel, out_score, out_last and out_idx.
- Tie priority is match > mismatch > gap, identical to the selector's priority. out_sel is always exactly one-hot while out_valid=1.
- Latency: 2 cycles from input handshake to out_valid when unstalled.
- Stall: while out_valid=1 and out_ready=0, every output is held stable. Stage 1 holds if it is full.
- Index counter:
  - out_idx is the counter value captured when the beat enters stage 2.
  - The counter increments on each stage-2 load and resets to 0 after loading a beat with last=1.
  - Wraps modulo 2^IDX_W with no flag.
- Simultaneous output handshake and new stage-2 load: the load wins and out_valid stays 1.

Optional Feature:
- Macro: SCORE_COMPARATOR_STATS_EN.
- Defined:
  - Adds output ports stat_match, stat_mismatch, stat_gap (each STAT_W) and input stat_clr (1).
  - Each counter increments on the output handshake of a beat with the matching out_sel.
  - Counters saturate at all-ones. stat_clr zeroes all three synchronously and takes priority over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the one-hot sel localparams SEL_MATCH=3'b100, SEL_MISMATCH=3'b010, SEL_GAP=3'b001, shared with the selector;
  - the default SCORE_W.
- One natural sub-module, score_max2: combinational signed 2-input max that returns the winner flag and score, with a tie-goes-to-first rule. It is instantiated once per stage.

Test Plan:
- match=5, mismatch=3, gap=-2, last=0, out_ready=1 -> two cycles later out_sel=100, out_score=5, out_idx=0.
- Ties: match=4, mismatch=4, gap=4 -> 100, score 4. Then match=-8, mismatch=1, gap=1 -> 010, score 1. Then match=-8, mismatch=-3, gap=-1 -> 001, score -1.
- Stream 6 beats back-to-back with last on beat 3, out_ready=1 -> out_idx sequence 0,1,2,0,1,2; in_ready never drops; one output per cycle.
- Hold out_ready=0 for 4 cycles with input streaming -> in_ready drops after 2 beats are captured; outputs stay stable; release yields beats in order with none lost or duplicated.
- Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 and out_idx=0 immediately (asynchronously); after release the first new beat has out_idx=0.
- With SCORE_COMPARATOR_STATS_EN: 3 match, 2 mismatch, 1 gap winners -> stat counters 3, 2, 1. stat_clr in the same cycle as an increment -> counters read 0.
